// File: rtl/fp8_pkg.sv
// E5M2 format constants and FP32 field widths shared by the down-converter and packer.
package fp8_pkg;
   localparam int EXP_W     = 5;
   localparam int MAN_W     = 2;
   localparam int BIAS      = 15;
   localparam logic [6:0] FP8_INF = 7'h7C;
   localparam logic [6:0] FP8_NAN = 7'h7F;
   localparam logic [6:0] FP8_MAX = 7'h7B;

   localparam int F32_EXP_W = 8;
   localparam int F32_MAN_W = 23;
   localparam int F32_BIAS  = 127;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp8_t;
endpackage

// File: rtl/fp32_to_e5m2.sv
// Combinational FP32 -> FP8 E5M2 conversion, round-to-nearest-even, with event flags.
// FP8_SAT_EN: finite overflow saturates to max normal instead of infinity.
module fp32_to_e5m2
   import fp8_pkg::*;
(
   input  logic [31:0] in,
   output logic [7:0]  out,
   output logic        ovf,
   output logic        uf,
   output logic        nan
);
   localparam int EXP_OFS = F32_BIAS - BIAS;

   logic                 sgn;
   logic [F32_EXP_W-1:0] e;
   logic [F32_MAN_W-1:0] m;
   fp8_t                 res;

   assign sgn = in[31];
   assign e   = in[30:23];
   assign m   = in[22:0];

   // Normal range: {rebiased exponent, top two mantissa bits}, carry ripples into exponent.
   logic [9:0] nrm_pre;
   logic [9:0] nrm_rnd;
   logic       nrm_up;
   logic       nrm_ovf;

   assign nrm_pre = {e - 8'(EXP_OFS), m[22:21]};
   assign nrm_up  = m[20] & ((|m[19:0]) | m[21]);
   assign nrm_rnd = nrm_pre + {9'd0, nrm_up};
   assign nrm_ovf = (nrm_rnd[9:2] >= 8'd31);

   // Subnormal range: y holds the significand aligned so y[26:25] is q in units of 2^-16.
   logic [1:0]  sub_t;
   logic [26:0] sub_y;
   logic        sub_up;
   logic [2:0]  sub_q;

   assign sub_t  = (e <= 8'd109) ? 2'd3 : 2'(8'd112 - e);
   assign sub_y  = {1'b1, m, 3'b000} >> sub_t;
   assign sub_up = sub_y[24] & ((|sub_y[23:0]) | sub_y[25]);
   assign sub_q  = {1'b0, sub_y[26:25]} + {2'b00, sub_up};

   always_comb begin
      res = {sgn, 7'h00};
      ovf = 1'b0;
      uf  = 1'b0;
      nan = 1'b0;
      if (e == '1) begin
         if (m == '0) begin
            res = {sgn, FP8_INF};
         end else begin
            res = {sgn, FP8_NAN};
            nan = 1'b1;
         end
      end else if (e > 8'(EXP_OFS)) begin
         if (nrm_ovf) begin
            ovf = 1'b1;
`ifdef FP8_SAT_EN
            res = {sgn, FP8_MAX};
`else
            res = {sgn, FP8_INF};
`endif
         end else begin
            res = {sgn, nrm_rnd[6:0]};
         end
      end else if (e != '0) begin
         res = {sgn, 4'h0, sub_q};
         uf  = (sub_q == 3'd0);
      end
   end

   assign out = res;
endmodule

// File: rtl/fp32_to_fp8_pack.sv
// Streams FP32 beats through an E5M2 converter and packs LANES bytes per word (lane 0 low).
// Latency 1 cycle from completing beat; in_ready = !out_valid || out_ready. FP8_SAT_EN selects saturation.
module fp32_to_fp8_pack
   import fp8_pkg::*;
#(
   parameter  int LANES = 4,
   localparam int OUT_W = 8 * LANES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [LANES-1:0] out_keep,
   input  logic             flag_clr,
   output logic             flag_ovf,
   output logic             flag_uf,
   output logic             flag_nan
);
   localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

   logic [CNT_W-1:0] cnt;
   logic [OUT_W-1:0] pack_buf;
   logic [OUT_W-1:0] buf_next;
   logic [LANES-1:0] keep_next;
   logic [7:0]       fp8_byte;
   logic             cv_ovf;
   logic             cv_uf;
   logic             cv_nan;
   logic             accept;
   logic             word_done;

   fp32_to_e5m2 u_conv (
      .in  (in_data),
      .out (fp8_byte),
      .ovf (cv_ovf),
      .uf  (cv_uf),
      .nan (cv_nan)
   );

   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign word_done = (cnt == CNT_W'(LANES - 1)) || in_last;

   always_comb begin
      buf_next  = pack_buf;
      keep_next = '0;
      for (int i = 0; i < LANES; i++) begin
         if (CNT_W'(i) == cnt) buf_next[8*i +: 8] = fp8_byte;
         if (CNT_W'(i) <= cnt) keep_next[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         pack_buf  <= '0;
         cnt       <= '0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (accept) begin
            if (word_done) begin
               out_valid <= 1'b1;
               out_data  <= buf_next;
               out_keep  <= keep_next;
               pack_buf  <= '0;
               cnt       <= '0;
            end else begin
               pack_buf <= buf_next;
               cnt      <= cnt + 1'b1;
            end
         end
      end
   end

   // Clear beats a same-cycle set.
   always_ff @(posedge clk) begin
      if (rst || flag_clr) begin
         flag_ovf <= 1'b0;
         flag_uf  <= 1'b0;
         flag_nan <= 1'b0;
      end else if (accept) begin
         flag_ovf <= flag_ovf | cv_ovf;
         flag_uf  <= flag_uf  | cv_uf;
         flag_nan <= flag_nan | cv_nan;
      end
   end
endmodule

// File: tb/tb_fp32_to_fp8_pack.sv
// Directed-vector bench for fp32_to_fp8_pack; expected bytes are hand-computed E5M2 encodings.
module tb_fp32_to_fp8_pack;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        flag_clr;
   logic        flag_ovf;
   logic        flag_uf;
   logic        flag_nan;

   int applied     = 0;
   int miscompares = 0;

`ifdef FP8_SAT_EN
   localparam logic [7:0] OVF_BYTE = 8'h7B;
`else
   localparam logic [7:0] OVF_BYTE = 8'h7C;
`endif

   always #5 clk = ~clk;

   fp32_to_fp8_pack #(.LANES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .flag_clr  (flag_clr),
      .flag_ovf  (flag_ovf),
      .flag_uf   (flag_uf),
      .flag_nan  (flag_nan)
   );

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input logic [31:0] d, input logic l);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         applied++; miscompares++;
         $display("FAIL send_timeout in_ready=%b required 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic clear_flags();
      flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      applied++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      applied++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
      applied++; if (out_keep !== 4'h0) begin miscompares++; $display("FAIL reset_out_keep got %h want 0", out_keep); end
      applied++; if ({flag_ovf, flag_uf, flag_nan} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {flag_ovf, flag_uf, flag_nan}); end
      applied++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_pack();
      out_ready = 1'b1;
      send(32'h3F800000, 1'b0);
      send(32'hC0000000, 1'b0);
      send(32'h3F000000, 1'b0);
      applied++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL pack_early_valid got %b want 0", out_valid); end
      send(32'h00000000, 1'b0);
      in_valid = 1'b0;
      applied++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL pack_valid got %b want 1", out_valid); end
      applied++; if (out_data !== 32'h0038C03C) begin miscompares++; $display("FAIL pack_data got %h want 0038c03c", out_data); end
      applied++; if (out_keep !== 4'hF) begin miscompares++; $display("FAIL pack_keep got %h want f", out_keep); end
      @(negedge clk);
      applied++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL pack_valid_drop got %b want 0", out_valid); end
   endtask

   task automatic test_convert();
      logic [31:0] vin  [10] = '{32'h3F900000, 32'h3FB00000, 32'h47600000, 32'hFF800000, 32'h80000000,
                                 32'h37800000, 32'h38000000, 32'h387FFFFF, 32'hC7800000, 32'h40000000};
      logic [7:0]  vexp [10] = '{8'h3C, 8'h3E, 8'h7B, 8'hFC, 8'h80,
                                 8'h01, 8'h02, 8'h04, {1'b1, OVF_BYTE[6:0]}, 8'h40};
      out_ready = 1'b1;
      clear_flags();
      for (int i = 0; i < 10; i++) begin
         send(vin[i], 1'b1);
         in_valid = 1'b0;
         applied++; if (out_keep !== 4'h1) begin miscompares++; $display("FAIL conv_keep[%0d] got %h want 1", i, out_keep); end
         applied++; if (out_data !== {24'h0, vexp[i]}) begin miscompares++; $display("FAIL conv_data[%0d] in %h got %h want %h", i, vin[i], out_data, {24'h0, vexp[i]}); end
         if (i == 7) begin
            applied++; if ({flag_ovf, flag_uf, flag_nan} !== 3'b000) begin miscompares++; $display("FAIL conv_no_flags got %b want 000", {flag_ovf, flag_uf, flag_nan}); end
         end
         @(negedge clk);
      end
      applied++; if (flag_ovf !== 1'b1) begin miscompares++; $display("FAIL conv_neg_ovf_flag got %b want 1", flag_ovf); end
   endtask

   task automatic test_overflow();
      out_ready = 1'b1;
      clear_flags();
      applied++; if (flag_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_cleared got %b want 0", flag_ovf); end
      send(32'h47700000, 1'b1);
      in_valid = 1'b0;
      applied++; if (out_data[7:0] !== OVF_BYTE) begin miscompares++; $display("FAIL ovf_round_data got %h want %h", out_data[7:0], OVF_BYTE); end
      applied++; if (flag_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_round_flag got %b want 1", flag_ovf); end
      @(negedge clk);
      send(32'h47800000, 1'b1);
      in_valid = 1'b0;
      applied++; if (out_data[7:0] !== OVF_BYTE) begin miscompares++; $display("FAIL ovf_exp_data got %h want %h", out_data[7:0], OVF_BYTE); end
      clear_flags();
      applied++; if (flag_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clr got %b want 0", flag_ovf); end
      // Overflow beat accepted together with a clear: clear must win.
      flag_clr = 1'b1;
      send(32'h47800000, 1'b1);
      in_valid = 1'b0;
      flag_clr = 1'b0;
      applied++; if (flag_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clr_priority got %b want 0", flag_ovf); end
      @(negedge clk);
   endtask

   task automatic test_small();
      out_ready = 1'b1;
      clear_flags();
      send(32'h36800000, 1'b1);
      in_valid = 1'b0;
      applied++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL uf_data got %h want 00000000", out_data); end
      applied++; if (flag_uf !== 1'b1) begin miscompares++; $display("FAIL uf_flag got %b want 1", flag_uf); end
      @(negedge clk);
      send(32'h7FC00000, 1'b1);
      in_valid = 1'b0;
      applied++; if (out_data !== 32'h7F) begin miscompares++; $display("FAIL nan_data got %h want 0000007f", out_data); end
      applied++; if (flag_nan !== 1'b1) begin miscompares++; $display("FAIL nan_flag got %b want 1", flag_nan); end
      applied++; if (flag_ovf !== 1'b0) begin miscompares++; $display("FAIL nan_no_ovf got %b want 0", flag_ovf); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      out_ready = 1'b0;
      send(32'h3F800000, 1'b0);
      send(32'hC0000000, 1'b1);
      in_valid = 1'b1;
      in_data  = 32'h40000000;
      in_last  = 1'b1;
      held     = out_data;
      applied++; if (out_keep !== 4'h3) begin miscompares++; $display("FAIL bp_keep got %h want 3", out_keep); end
      applied++; if (out_data !== 32'h0000C03C) begin miscompares++; $display("FAIL bp_data got %h want 0000c03c", out_data); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         applied++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
         applied++; if (out_valid !== 1'b1 || out_data !== held) begin miscompares++; $display("FAIL bp_hold[%0d] got %b/%h want 1/%h", i, out_valid, out_data, held); end
      end
      out_ready = 1'b1;
      #1;
      applied++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release got %b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      applied++; if (out_valid !== 1'b1 || out_data !== 32'h40 || out_keep !== 4'h1) begin miscompares++; $display("FAIL bp_next_word got %b/%h/%h want 1/00000040/1", out_valid, out_data, out_keep); end
      @(negedge clk);
      applied++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drop got %b want 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      clear_flags();
      send(32'h7FC00000, 1'b0);
      send(32'h3F800000, 1'b0);
      in_valid = 1'b0;
      applied++; if (flag_nan !== 1'b1) begin miscompares++; $display("FAIL mid_nan_before got %b want 1", flag_nan); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      applied++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_keep !== 4'h0) begin miscompares++; $display("FAIL mid_reset_out got %b/%h/%h want 0/00000000/0", out_valid, out_data, out_keep); end
      applied++; if ({flag_ovf, flag_uf, flag_nan} !== 3'b000) begin miscompares++; $display("FAIL mid_reset_flags got %b want 000", {flag_ovf, flag_uf, flag_nan}); end
      send(32'h3F800000, 1'b0);
      send(32'hC0000000, 1'b0);
      applied++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale_cnt got %b want 0", out_valid); end
      send(32'h3F000000, 1'b0);
      send(32'h00000000, 1'b0);
      in_valid = 1'b0;
      applied++; if (out_valid !== 1'b1 || out_data !== 32'h0038C03C || out_keep !== 4'hF) begin miscompares++; $display("FAIL mid_fresh_word got %b/%h/%h want 1/0038c03c/f", out_valid, out_data, out_keep); end
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      flag_clr  = 1'b0;
      @(negedge clk);
      test_reset();
      test_pack();
      test_convert();
      test_overflow();
      test_small();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
endmodule
